multicycle_main_controller: RTL and testbench
=============================================

Name: multicycle_main_controller

Overview:
- Control unit for the RV32I multi-cycle datapath: main FSM, ALU decoder, immediate-select decoder and PC-write logic.
- Sequences PC, IR, OldPC, A/B, ALUOut and Data registers, unified memory and register file, one instruction at a time.
- Supports lw, sw, R-type, I-type ALU, beq/bne, jal, auipc and lui.
- Also provides a retired-instruction counter and an illegal-opcode pulse.

Parameters:
RETIRE_W, 32, width of retired-instruction counter (wraps modulo 2^RETIRE_W)
ENABLE_BNE, 1, 1 = funct3 001 on branch opcode is bne; 0 = treated as illegal

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
op  input  7  instr[6:0] from IR
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU zero flag (combinational, current cycle)
pc_write  output  1  PC register enable
adr_src  output  1  memory address: 0 = PC, 1 = Result
mem_write  output  1  memory write strobe
ir_write  output  1  IR/OldPC enable
result_src  output  2  00 ALUOut, 01 Data, 10 ALUResult
alu_src_a  output  2  00 PC, 01 OldPC, 10 A(RD1), 11 constant 0
alu_src_b  output  2  00 B(RD2), 01 ImmExt, 10 constant 4
alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
imm_src  output  3  000 I, 001 S, 010 B, 011 J, 100 U
reg_write  output  1  register-file write enable
illegal_op  output  1  one-cycle pulse in DECODE on unsupported opcode/funct3
retired  output  RETIRE_W  count of completed instructions
state_dbg  output  4  current state encoding

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, AUIPC=11, LUI=12. Codes 13–15 go to FETCH on the next edge, with no enables asserted.
- Reset (reset=0, async):
  - State = FETCH; retired = 0.
  - pc_write, ir_write, mem_write, reg_write, illegal_op are forced 0 combinationally while reset=0.
  - First FETCH action happens on the first rising edge after reset returns to 1.
  - Reset asserted mid-instruction aborts it with no further writes and no retire count.
- Per-state outputs (unlisted controls are 0 / 00; alu_op is internal):
  - FETCH: adr_src=0, ir_write=1, A=00, B=10, alu_op=add, result_src=10, pc_update=1 → DECODE.
  - DECODE: A=01, B=01, alu_op=add (branch target into ALUOut).
    - Next state from op: 0000011/0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH; 1101111 → JAL; 0010111 → AUIPC; 0110111 → LUI.
    - Anything else, or a branch with unsupported funct3: illegal_op=1 → FETCH.
  - MEMADR: A=10, B=01, alu_op=add → MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: result_src=00, adr_src=1 → MEMWB.
  - MEMWB: result_src=01, reg_write=1 → FETCH.
  - MEMWRITE: result_src=00, adr_src=1, mem_write=1 → FETCH.
  - EXECR: A=10, B=00, alu_op=funct → ALUWB.
  - EXECI: A=10, B=01, alu_op=funct → ALUWB.
  - ALUWB: result_src=00, reg_write=1 → FETCH.
  - BRANCH: A=10, B=00, alu_op=sub, result_src=00, branch=1 → FETCH.
  - JAL: A=01, B=10, alu_op=add, result_src=00, pc_update=1 → ALUWB.
  - AUIPC: A=01, B=01, alu_op=add → ALUWB.
  - LUI: A=11, B=01, alu_op=add → ALUWB.
- pc_write = pc_update | (branch & (funct3[0] ? ~zero : zero)).
- alu_control:
  - add → 000; sub → 001.
  - funct, by funct3: 000 → sub if (op[5] & funct7b5), else add; 010 → slt; 110 → or; 111 → and; others → add.
- imm_src is combinational from op regardless of state: 0100011 → S; 1100011 → B; 1101111 → J; 0010111/0110111 → U; else I.
- retired increments on every edge leaving MEMWB, MEMWRITE, ALUWB or BRANCH (the final state of each instruction). It does not increment on illegal instructions.
- CPI:
  - lw = 5
  - sw, R-type, I-type, auipc, lui = 4
  - branch = 3
  - jal = 4

Test Plan:
- Reset held 0 for 2 edges → state_dbg=0, all enables 0, retired=0. Release → cycle 1 has ir_write=1 and pc_write=1.
- op=0010111 (auipc) → states 0,1,11,8,0. In AUIPC: alu_src_a=01, alu_src_b=01, imm_src=100. reg_write=1 only in ALUWB; retired=1 after 4 cycles.
- op=0100011 (sw) → 0,1,2,5,0. mem_write=1 and adr_src=1 for exactly 1 cycle; imm_src=001.
- op=1100011, funct3=000, zero=1 in BRANCH → pc_write=1. Same with zero=0 → pc_write=0. funct3=001, zero=0 → pc_write=1. funct3=100 → illegal_op pulse in DECODE, retired unchanged.
- op=0110011, funct3=000, funct7b5=1 → alu_control=001 in EXECR. funct3=111 → 010. op=0010011, funct7b5=1, funct3=000 → 000 (addi, not sub).
- Reset dropped to 0 during MEMREAD of lw → outputs immediately gated, no reg_write. After release, the restart is at FETCH and retired is unchanged at 0.

Source files
------------

// File: rtl/multicycle_main_controller.sv
// RV32I multi-cycle main controller: sequencing FSM, ALU decode,
// immediate select, PC-write logic and retired-instruction counter.
module multicycle_main_controller #(
    parameter int RETIRE_W   = 32,
    parameter bit ENABLE_BNE = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic                funct7b5,
    input  logic                zero,
    output logic                pc_write,
    output logic                adr_src,
    output logic                mem_write,
    output logic                ir_write,
    output logic [1:0]          result_src,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [2:0]          alu_control,
    output logic [2:0]          imm_src,
    output logic                reg_write,
    output logic                illegal_op,
    output logic [RETIRE_W-1:0] retired,
    output logic [3:0]          state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        AUIPC    = 4'd11,
        LUI      = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        AOP_ADD,
        AOP_SUB,
        AOP_FUNCT
    } alu_op_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    state_t  state;
    state_t  state_nx;
    alu_op_t alu_op;
    logic    pc_update;
    logic    branch;
    logic    ir_w;
    logic    mem_w;
    logic    reg_w;
    logic    ill;
    logic    br_f3_ok;
    logic    br_cond;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= state_nx;
    end

    assign br_f3_ok = (funct3 == 3'b000) ||
                      (ENABLE_BNE && (funct3 == 3'b001));

    always_comb begin
        state_nx   = FETCH;
        alu_op     = AOP_ADD;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_w       = 1'b0;
        mem_w      = 1'b0;
        reg_w      = 1'b0;
        ill        = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        case (state)
            FETCH: begin
                ir_w       = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
                state_nx   = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_nx = MEMADR;
                    OP_R:         state_nx = EXECR;
                    OP_I:         state_nx = EXECI;
                    OP_JAL:       state_nx = JAL;
                    OP_AUIPC:     state_nx = AUIPC;
                    OP_LUI:       state_nx = LUI;
                    OP_BR: begin
                        if (br_f3_ok) state_nx = BRANCH;
                        else          ill      = 1'b1;
                    end
                    default:      ill      = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_nx  = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src  = 1'b1;
                state_nx = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
            end
            MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = AOP_FUNCT;
                state_nx  = ALUWB;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = AOP_FUNCT;
                state_nx  = ALUWB;
            end
            ALUWB: reg_w = 1'b1;
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = AOP_SUB;
                branch    = 1'b1;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_nx  = ALUWB;
            end
            AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                state_nx  = ALUWB;
            end
            LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_nx  = ALUWB;
            end
            default: state_nx = FETCH;
        endcase
    end

    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            AOP_SUB: alu_control = 3'b001;
            AOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op[5] & funct7b5) ?
                                           3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    always_comb begin
        imm_src = 3'b000;
        unique case (1'b1)
            (op == OP_SW):    imm_src = 3'b001;
            (op == OP_BR):    imm_src = 3'b010;
            (op == OP_JAL):   imm_src = 3'b011;
            (op == OP_AUIPC),
            (op == OP_LUI):   imm_src = 3'b100;
            default:          imm_src = 3'b000;
        endcase
    end

    // bit 0 of funct3 distinguishes bne from beq
    assign br_cond    = funct3[0] ? ~zero : zero;
    assign pc_write   = reset & (pc_update | (branch & br_cond));
    assign ir_write   = reset & ir_w;
    assign mem_write  = reset & mem_w;
    assign reg_write  = reset & reg_w;
    assign illegal_op = reset & ill;
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired <= '0;
        end else if (state == MEMWB || state == MEMWRITE ||
                     state == ALUWB || state == BRANCH) begin
            retired <= retired + {{(RETIRE_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Table-driven bench for multicycle_main_controller with an
// expected-result queue popped as each instruction completes.
module tb_multicycle_main_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        pc_write;
    logic        adr_src;
    logic        mem_write;
    logic        ir_write;
    logic [1:0]  result_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_control;
    logic [2:0]  imm_src;
    logic        reg_write;
    logic        illegal_op;
    logic [31:0] retired;
    logic [3:0]  state_dbg;

    multicycle_main_controller #(
        .RETIRE_W   (32),
        .ENABLE_BNE (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .imm_src     (imm_src),
        .reg_write   (reg_write),
        .illegal_op  (illegal_op),
        .retired     (retired),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]      op;
        logic [2:0]      f3;
        logic            f7;
        logic            z;
        int              cpi;
        logic [4:0][3:0] seq;
        int              pw;
        int              rw;
        int              mw;
        int              adr;
        logic            ill;
        logic [2:0]      alu;
        logic [1:0]      a;
        logic [1:0]      b;
        logic [2:0]      imm;
        int              ret;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_cmp = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] sq(input logic [3:0] s0, s1, s2,
                                       s3, s4);
        return {s4, s3, s2, s1, s0};
    endfunction

    function automatic vec_t mk(
        input logic [6:0] o, input logic [2:0] f3,
        input logic f7, input logic z, input int cpi,
        input logic [19:0] s, input int pw, rw, mw, adr,
        input logic ill, input logic [2:0] alu,
        input logic [1:0] a, b, input logic [2:0] imm,
        input int ret);
        vec_t v;
        v.op = o;   v.f3 = f3;   v.f7 = f7;   v.z = z;
        v.cpi = cpi; v.seq = s;
        v.pw = pw;  v.rw = rw;   v.mw = mw;   v.adr = adr;
        v.ill = ill; v.alu = alu; v.a = a;    v.b = b;
        v.imm = imm; v.ret = ret;
        return v;
    endfunction

    // entered with state_dbg == FETCH, returns at the next FETCH
    task automatic run_vec(input vec_t v, input int idx);
        vec_t o;
        vec_t e;
        int   r0;
        int   k;
        string t;
        op = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.z;
        exp_q.push_back(v);
        o.seq = '0; o.pw = 0; o.rw = 0; o.mw = 0; o.adr = 0;
        o.ill = 1'b0; o.alu = '0; o.a = '0; o.b = '0;
        o.imm = '0;
        r0 = int'(retired);
        #1;
        k = 0;
        while (1) begin
            if (k < 5) o.seq[k] = state_dbg;
            o.pw  += int'(pc_write);
            o.rw  += int'(reg_write);
            o.mw  += int'(mem_write);
            o.adr += int'(adr_src);
            o.ill |= illegal_op;
            if (k == 1) o.imm = imm_src;
            if (k == 1 || k == 2) begin
                o.alu = alu_control;
                o.a   = alu_src_a;
                o.b   = alu_src_b;
            end
            k++;
            @(negedge clk);
            #1;
            if (state_dbg == 4'd0 || k >= 8) break;
        end
        o.cpi = k;
        o.ret = int'(retired) - r0;
        e = exp_q.pop_front();
        t = $sformatf("v%0d", idx);
        check({t, " cpi"}, o.cpi, e.cpi);
        check({t, " states"}, 32'(o.seq), 32'(e.seq));
        check({t, " pc_write cycles"}, o.pw, e.pw);
        check({t, " reg_write cycles"}, o.rw, e.rw);
        check({t, " mem_write cycles"}, o.mw, e.mw);
        check({t, " adr_src cycles"}, o.adr, e.adr);
        check({t, " illegal_op"}, 32'(o.ill), 32'(e.ill));
        check({t, " alu_control"}, 32'(o.alu), 32'(e.alu));
        check({t, " alu_src_a"}, 32'(o.a), 32'(e.a));
        check({t, " alu_src_b"}, 32'(o.b), 32'(e.b));
        check({t, " imm_src"}, 32'(o.imm), 32'(e.imm));
        check({t, " retired delta"}, o.ret, e.ret);
        n_vec++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // op, f3, f7, z, cpi, states, pw, rw, mw, adr,
        // ill, alu, a, b, imm, ret
        tbl.push_back(mk(7'b0000011, 3'b010, 0, 0, 5,
            sq(0, 1, 2, 3, 4), 1, 1, 0, 1,
            0, 3'b000, 2'b10, 2'b01, 3'b000, 1));
        tbl.push_back(mk(7'b0100011, 3'b010, 0, 0, 4,
            sq(0, 1, 2, 5, 0), 1, 0, 1, 1,
            0, 3'b000, 2'b10, 2'b01, 3'b001, 1));
        tbl.push_back(mk(7'b0110011, 3'b000, 0, 0, 4,
            sq(0, 1, 6, 8, 0), 1, 1, 0, 0,
            0, 3'b000, 2'b10, 2'b00, 3'b000, 1));
        tbl.push_back(mk(7'b0110011, 3'b000, 1, 0, 4,
            sq(0, 1, 6, 8, 0), 1, 1, 0, 0,
            0, 3'b001, 2'b10, 2'b00, 3'b000, 1));
        tbl.push_back(mk(7'b0110011, 3'b111, 0, 0, 4,
            sq(0, 1, 6, 8, 0), 1, 1, 0, 0,
            0, 3'b010, 2'b10, 2'b00, 3'b000, 1));
        tbl.push_back(mk(7'b0110011, 3'b110, 0, 0, 4,
            sq(0, 1, 6, 8, 0), 1, 1, 0, 0,
            0, 3'b011, 2'b10, 2'b00, 3'b000, 1));
        tbl.push_back(mk(7'b0110011, 3'b010, 0, 0, 4,
            sq(0, 1, 6, 8, 0), 1, 1, 0, 0,
            0, 3'b101, 2'b10, 2'b00, 3'b000, 1));
        tbl.push_back(mk(7'b0110011, 3'b001, 0, 0, 4,
            sq(0, 1, 6, 8, 0), 1, 1, 0, 0,
            0, 3'b000, 2'b10, 2'b00, 3'b000, 1));
        tbl.push_back(mk(7'b0010011, 3'b000, 1, 0, 4,
            sq(0, 1, 7, 8, 0), 1, 1, 0, 0,
            0, 3'b000, 2'b10, 2'b01, 3'b000, 1));
        tbl.push_back(mk(7'b0010011, 3'b010, 0, 0, 4,
            sq(0, 1, 7, 8, 0), 1, 1, 0, 0,
            0, 3'b101, 2'b10, 2'b01, 3'b000, 1));
        tbl.push_back(mk(7'b0010011, 3'b110, 0, 0, 4,
            sq(0, 1, 7, 8, 0), 1, 1, 0, 0,
            0, 3'b011, 2'b10, 2'b01, 3'b000, 1));
        tbl.push_back(mk(7'b1100011, 3'b000, 0, 1, 3,
            sq(0, 1, 9, 0, 0), 2, 0, 0, 0,
            0, 3'b001, 2'b10, 2'b00, 3'b010, 1));
        tbl.push_back(mk(7'b1100011, 3'b000, 0, 0, 3,
            sq(0, 1, 9, 0, 0), 1, 0, 0, 0,
            0, 3'b001, 2'b10, 2'b00, 3'b010, 1));
        tbl.push_back(mk(7'b1100011, 3'b001, 0, 0, 3,
            sq(0, 1, 9, 0, 0), 2, 0, 0, 0,
            0, 3'b001, 2'b10, 2'b00, 3'b010, 1));
        tbl.push_back(mk(7'b1100011, 3'b001, 0, 1, 3,
            sq(0, 1, 9, 0, 0), 1, 0, 0, 0,
            0, 3'b001, 2'b10, 2'b00, 3'b010, 1));
        tbl.push_back(mk(7'b1101111, 3'b000, 0, 0, 4,
            sq(0, 1, 10, 8, 0), 2, 1, 0, 0,
            0, 3'b000, 2'b01, 2'b10, 3'b011, 1));
        tbl.push_back(mk(7'b0010111, 3'b000, 0, 0, 4,
            sq(0, 1, 11, 8, 0), 1, 1, 0, 0,
            0, 3'b000, 2'b01, 2'b01, 3'b100, 1));
        tbl.push_back(mk(7'b0110111, 3'b000, 0, 0, 4,
            sq(0, 1, 12, 8, 0), 1, 1, 0, 0,
            0, 3'b000, 2'b11, 2'b01, 3'b100, 1));
        tbl.push_back(mk(7'b1100011, 3'b100, 0, 0, 2,
            sq(0, 1, 0, 0, 0), 1, 0, 0, 0,
            1, 3'b000, 2'b01, 2'b01, 3'b010, 0));
        tbl.push_back(mk(7'b1111111, 3'b000, 0, 0, 2,
            sq(0, 1, 0, 0, 0), 1, 0, 0, 0,
            1, 3'b000, 2'b01, 2'b01, 3'b000, 0));

        reset = 1'b0; op = '0; funct3 = '0;
        funct7b5 = 1'b0; zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset state", 32'(state_dbg), 0);
        check("reset pc_write", 32'(pc_write), 0);
        check("reset ir_write", 32'(ir_write), 0);
        check("reset mem_write", 32'(mem_write), 0);
        check("reset reg_write", 32'(reg_write), 0);
        check("reset illegal_op", 32'(illegal_op), 0);
        check("reset retired", retired, 0);
        n_vec++;

        @(negedge clk);
        reset = 1'b1;
        #1;
        check("first fetch ir_write", 32'(ir_write), 1);
        check("first fetch pc_write", 32'(pc_write), 1);
        check("first fetch state", 32'(state_dbg), 0);
        n_vec++;

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

        // reset dropped while a load sits in MEMREAD
        op = 7'b0000011; funct3 = 3'b010;
        funct7b5 = 1'b0; zero = 1'b0;
        #1;
        repeat (3) @(negedge clk);
        #1;
        check("midreset in MEMREAD", 32'(state_dbg), 3);
        check("midreset adr_src", 32'(adr_src), 1);
        reset = 1'b0;
        #1;
        check("midreset state", 32'(state_dbg), 0);
        check("midreset reg_write", 32'(reg_write), 0);
        check("midreset pc_write", 32'(pc_write), 0);
        check("midreset ir_write", 32'(ir_write), 0);
        check("midreset mem_write", 32'(mem_write), 0);
        check("midreset retired", retired, 0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("midreset hold reg_write", 32'(reg_write), 0);
            check("midreset hold state", 32'(state_dbg), 0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("restart state", 32'(state_dbg), 0);
        check("restart ir_write", 32'(ir_write), 1);
        check("restart retired", retired, 0);
        n_vec++;

        run_vec(tbl[0], 100);
        check("retired after restart lw", retired, 1);
        n_vec++;

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
